// File: rtl/ps2_mouse_packet.sv
// ---------------------------------------------------------------------------
// PS2MousePacket (module ps2_mouse_packet)
//
// Purpose:
//   Assembles standard 3-byte PS/2 mouse stream packets from the byte
//   receiver, reports the signed movement and button state of each packet,
//   and integrates X movement into a clamped ship position for the player
//   cannon. A fire strobe is produced when the left button goes down.
//
// Ports:
//   i_clk            system clock
//   i_reset          synchronous, active-high reset
//   i_rx_done_tick   one-cycle strobe, i_rx_data holds a received byte
//   i_rx_data[7:0]   received byte
//   o_xm[8:0]        signed dx of last packet (two's complement)
//   o_ym[8:0]        signed dy of last packet
//   o_btnm[2:0]      {middle, right, left} of last packet
//   o_m_done_tick    one-cycle pulse, xm/ym/btnm valid (ship_x follows)
//   o_ship_x[9:0]    clamped integrated X position
//   o_fire_tick      one-cycle pulse on left-button rising edge
// ---------------------------------------------------------------------------
module ps2_mouse_packet #(
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 608,
    parameter int X_INIT  = 304,
    parameter int SHIFT   = 1,
    parameter int TIMEOUT = 50000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx_done_tick,
    input  logic [7:0] i_rx_data,
    output logic [8:0] o_xm,
    output logic [8:0] o_ym,
    output logic [2:0] o_btnm,
    output logic       o_m_done_tick,
    output logic [9:0] o_ship_x,
    output logic       o_fire_tick
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] C_TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic signed [10:0] C_MIN = 11'(X_MIN);
    localparam logic signed [10:0] C_MAX = 11'(X_MAX);

    typedef enum logic [1:0] {B1, B2, B3, DONE} state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [6:0]      r_hdr;
    logic [7:0]      r_dx;
    logic [8:0]      r_xm;
    logic [8:0]      r_ym;
    logic [2:0]      r_btn;
    logic [9:0]      r_shipX;
    logic            r_prevLeft;
    logic [TW-1:0]   r_timer;

    logic            w_loadHdr;
    logic            w_loadDx;
    logic            w_loadPkt;
    logic            w_timerClr;
    logic            w_timedOut;
    logic            w_isHeader;
    logic [8:0]      w_xmNew;
    logic [8:0]      w_ymNew;
    logic signed [10:0] w_delta;
    logic signed [10:0] w_sum;
    logic [9:0]      w_shipNext;

    // r_hdr packs the header without bit 3 (always 1, used only for sync):
    // r_hdr = {yOvf, xOvf, ySign, xSign, middle, right, left}
    assign w_isHeader = i_rx_done_tick && i_rx_data[3];
    assign w_timedOut = (r_timer == C_TIMER_LAST);

    // Next-state decode. B1, DONE and an expiring timeout all treat an
    // incoming byte as a header attempt, so a byte arriving in DONE or at
    // the moment of resync is never lost.
    always_comb begin
        w_nextState = r_state;
        w_loadHdr   = 1'b0;
        w_loadDx    = 1'b0;
        w_loadPkt   = 1'b0;
        w_timerClr  = 1'b0;
        case (r_state)
            B1, DONE: begin
                w_timerClr = 1'b1;
                if (w_isHeader) begin
                    w_loadHdr   = 1'b1;
                    w_nextState = B2;
                end else begin
                    w_nextState = B1;
                end
            end
            B2, B3: begin
                if (w_timedOut) begin
                    w_timerClr = 1'b1;
                    if (w_isHeader) begin
                        w_loadHdr   = 1'b1;
                        w_nextState = B2;
                    end else begin
                        w_nextState = B1;
                    end
                end else if (i_rx_done_tick) begin
                    w_timerClr = 1'b1;
                    if (r_state == B2) begin
                        w_loadDx    = 1'b1;
                        w_nextState = B3;
                    end else begin
                        w_loadPkt   = 1'b1;
                        w_nextState = DONE;
                    end
                end
            end
            default: begin
                w_nextState = B1;
                w_timerClr  = 1'b1;
            end
        endcase
    end

    // Movement decode with overflow saturation: an overflowed axis pins to
    // +255 or -256 according to its sign bit, ignoring the data byte.
    always_comb begin
        w_xmNew = {r_hdr[3], r_dx};
        w_ymNew = {r_hdr[4], i_rx_data};
        if (r_hdr[5]) begin
            w_xmNew = r_hdr[3] ? 9'h100 : 9'h0FF;
        end
        if (r_hdr[6]) begin
            w_ymNew = r_hdr[4] ? 9'h100 : 9'h0FF;
        end
    end

    // Ship integration in 11-bit signed so the sum can go below zero or past
    // X_MAX before clamping.
    always_comb begin
        w_delta = $signed({{2{r_xm[8]}}, r_xm}) >>> SHIFT;
        w_sum   = $signed({1'b0, r_shipX}) + w_delta;
        if (w_sum < C_MIN) begin
            w_shipNext = C_MIN[9:0];
        end else if (w_sum > C_MAX) begin
            w_shipNext = C_MAX[9:0];
        end else begin
            w_shipNext = w_sum[9:0];
        end
    end

    // State register and idle-timeout counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= B1;
            r_timer <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_timerClr) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    // Packet capture. Outputs are latched at the edge that accepts the dy
    // byte so they are already valid during the DONE cycle. Ship position
    // and the previous-left history advance at the DONE edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hdr      <= '0;
            r_dx       <= '0;
            r_xm       <= '0;
            r_ym       <= '0;
            r_btn      <= '0;
            r_shipX    <= 10'(X_INIT);
            r_prevLeft <= 1'b0;
        end else begin
            if (w_loadHdr) begin
                r_hdr <= {i_rx_data[7:4], i_rx_data[2:0]};
            end
            if (w_loadDx) begin
                r_dx <= i_rx_data;
            end
            if (w_loadPkt) begin
                r_xm  <= w_xmNew;
                r_ym  <= w_ymNew;
                r_btn <= r_hdr[2:0];
            end
            if (r_state == DONE) begin
                r_shipX    <= w_shipNext;
                r_prevLeft <= r_btn[0];
            end
        end
    end

    assign o_xm          = r_xm;
    assign o_ym          = r_ym;
    assign o_btnm        = r_btn;
    assign o_ship_x      = r_shipX;
    assign o_m_done_tick = (r_state == DONE);
    assign o_fire_tick   = (r_state == DONE) && r_btn[0] && !r_prevLeft;

endmodule
